// File: rtl/coin_pkg.sv
// coin_pkg: coin values, FSM states and coin-select encoding shared by the credit controller.
package coin_pkg;
  localparam int NICKEL_CENTS  = 5;
  localparam int DIME_CENTS    = 10;
  localparam int QUARTER_CENTS = 25;
  typedef enum logic [1:0] {ACCUM, VEND, CHANGE, WAIT_ACK} state_t;
  typedef enum logic [1:0] {NONE, NICKEL, DIME, QUARTER} coin_sel_t;
  function automatic int unsigned coin_cents(input coin_sel_t c);
    return c == QUARTER ? QUARTER_CENTS : c == DIME ? DIME_CENTS : c == NICKEL ? NICKEL_CENTS : 0;
  endfunction
endpackage

// File: rtl/coin_edge_detect.sv
// coin_edge_detect: rising-edge pulses for the three coin detector levels.
module coin_edge_detect (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] i_level,
  output logic [2:0] o_rise
);
  logic [2:0] r_prev;
  always_ff @(posedge clk or posedge reset)
    if (reset) r_prev <= '0;
    else r_prev <= i_level;
  assign o_rise = i_level & ~r_prev;
endmodule

// File: rtl/coin_credit_controller.sv
// coin_credit_controller: coin credit accumulator, vend decision and one-coin-at-a-time change payout.
// Define COIN_CANCEL_EN to let cancelReq refund the whole balance from ACCUM.
module coin_credit_controller
  import coin_pkg::*;
#(
  parameter int price       = 65,
  parameter int maxCredit   = 200,
  parameter int creditWidth = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   dimeDetected,
  input  logic                   nickelDetected,
  input  logic                   quarterDetected,
  input  logic                   vendReq,
  input  logic                   cancelReq,
  input  logic                   dispenseAck,
  output logic [creditWidth-1:0] credit,
  output logic                   vend,
  output logic                   coinReject,
  output logic                   lowCredit,
  output logic                   dispQuarter,
  output logic                   dispDime,
  output logic                   dispNickel
);
  localparam int CW1 = creditWidth + 1;
  state_t                 r_state;
  logic [creditWidth-1:0] r_credit;
  logic                   r_vend, r_reject, r_low;
  logic [2:0]             r_disp;
  logic [2:0]             w_rise;
  coin_sel_t              w_coin, w_chg_sel;
  logic                   w_multi, w_accept, w_reject, w_can_vend, w_cancel;
  logic [creditWidth:0]   w_sum;
  logic [creditWidth-1:0] w_disp_val;
  coin_edge_detect u_edge (
    .clk    (clk),
    .reset  (reset),
    .i_level({quarterDetected, nickelDetected, dimeDetected}),
    .o_rise (w_rise)
  );
  always_comb begin
    w_coin     = w_rise[2] ? QUARTER : w_rise[1] ? NICKEL : w_rise[0] ? DIME : NONE;
    w_multi    = (w_rise[2] & (w_rise[1] | w_rise[0])) | (w_rise[1] & w_rise[0]);
    w_sum      = {1'b0, r_credit} + CW1'(coin_cents(w_coin));
    w_accept   = r_state == ACCUM && w_coin != NONE && w_sum <= CW1'(maxCredit);
    w_reject   = w_multi | (w_coin != NONE && !w_accept);
    w_can_vend = r_credit >= creditWidth'(price);
    w_chg_sel  = r_credit >= creditWidth'(QUARTER_CENTS) ? QUARTER :
                 r_credit >= creditWidth'(DIME_CENTS) ? DIME :
                 r_credit >= creditWidth'(NICKEL_CENTS) ? NICKEL : NONE;
    w_disp_val = r_disp[2] ? creditWidth'(QUARTER_CENTS) :
                 r_disp[1] ? creditWidth'(DIME_CENTS) : creditWidth'(NICKEL_CENTS);
  end
`ifdef COIN_CANCEL_EN
  assign w_cancel = cancelReq && r_credit != '0;
`else
  logic w_unused_cancel;
  assign w_unused_cancel = cancelReq;
  assign w_cancel = 1'b0;
`endif
  // Coin crediting in ACCUM uses w_sum, while the vend decision looks at the pre-coin r_credit.
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state  <= ACCUM;
      r_credit <= '0;
      r_vend   <= 1'b0;
      r_reject <= 1'b0;
      r_low    <= 1'b0;
      r_disp   <= '0;
    end else begin
      r_vend   <= 1'b0;
      r_low    <= 1'b0;
      r_reject <= w_reject;
      case (r_state)
        ACCUM: begin
          if (w_accept) r_credit <= w_sum[creditWidth-1:0];
          if (w_cancel) r_state <= CHANGE;
          else if (vendReq && w_can_vend) begin
            r_state <= VEND;
            r_vend  <= 1'b1;
          end else if (vendReq) r_low <= 1'b1;
        end
        VEND: begin
          r_credit <= r_credit - creditWidth'(price);
          r_state  <= r_credit == creditWidth'(price) ? ACCUM : CHANGE;
        end
        CHANGE:
          if (w_chg_sel == NONE) r_state <= ACCUM;
          else begin
            r_disp  <= {w_chg_sel == QUARTER, w_chg_sel == DIME, w_chg_sel == NICKEL};
            r_state <= WAIT_ACK;
          end
        WAIT_ACK:
          if (dispenseAck) begin
            r_disp   <= '0;
            r_credit <= r_credit - w_disp_val;
            r_state  <= CHANGE;
          end
        default: r_state <= ACCUM;
      endcase
    end
  assign credit      = r_credit;
  assign vend        = r_vend;
  assign coinReject  = r_reject;
  assign lowCredit   = r_low;
  assign dispQuarter = r_disp[2];
  assign dispDime    = r_disp[1];
  assign dispNickel  = r_disp[0];
endmodule

// File: tb/tb_coin_credit_controller.sv
// tb_coin_credit_controller: directed vectors with hand-computed expectations for coin_credit_controller.
module tb_coin_credit_controller;
  logic       clk = 0, reset = 1;
  logic       dimeDetected = 0, nickelDetected = 0, quarterDetected = 0;
  logic       vendReq = 0, cancelReq = 0, dispenseAck = 0;
  logic [7:0] credit;
  logic       vend, coinReject, lowCredit, dispQuarter, dispDime, dispNickel;
  int         n_vec = 0, n_err = 0;
  coin_credit_controller dut (
    .clk(clk), .reset(reset), .dimeDetected(dimeDetected), .nickelDetected(nickelDetected),
    .quarterDetected(quarterDetected), .vendReq(vendReq), .cancelReq(cancelReq),
    .dispenseAck(dispenseAck), .credit(credit), .vend(vend), .coinReject(coinReject),
    .lowCredit(lowCredit), .dispQuarter(dispQuarter), .dispDime(dispDime), .dispNickel(dispNickel)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] disp();
    return {29'd0, dispQuarter, dispDime, dispNickel};
  endfunction
  task automatic coin(input int c, input logic [7:0] exp_cr, input logic exp_rej);
    quarterDetected = c == 25;
    dimeDetected    = c == 10;
    nickelDetected  = c == 5;
    tick;
    chk("coin_credit", credit, exp_cr);
    chk("coin_reject", coinReject, exp_rej);
    tick;
    chk("reject_one_cycle", coinReject, 0);
    tick;
    {quarterDetected, dimeDetected, nickelDetected} = 3'b000;
    tick;
  endtask
  task automatic ack_coin(input logic [7:0] exp_cr);
    dispenseAck = 1;
    tick;
    chk("ack_disp_drop", disp(), 0);
    chk("ack_credit", credit, exp_cr);
    dispenseAck = 0;
    tick;
  endtask
  initial begin
    tick;
    tick;
    chk("rst_credit", credit, 0);
    chk("rst_pulses", {vend, coinReject, lowCredit}, 0);
    chk("rst_disp", disp(), 0);
    reset = 0;
    tick;
    coin(25, 25, 0);
    coin(25, 50, 0);
    coin(10, 60, 0);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("low_pulse", lowCredit, 1);
    chk("low_novend", vend, 0);
    chk("low_credit", credit, 60);
    tick;
    chk("low_one_cycle", lowCredit, 0);
    coin(5, 65, 0);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("exact_vend", vend, 1);
    chk("exact_credit_hold", credit, 65);
    tick;
    chk("exact_vend_one", vend, 0);
    chk("exact_credit", credit, 0);
    chk("exact_nodisp", disp(), 0);
    tick;
    chk("exact_nodisp2", disp(), 0);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("exact_back_accum", lowCredit, 1);
    for (int i = 1; i <= 4; i++) coin(25, 8'(25 * i), 0);
    dispenseAck = 1;
    tick;
    dispenseAck = 0;
    chk("ack_ignored_accum", credit, 100);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("chg_vend", vend, 1);
    tick;
    chk("chg_credit35", credit, 35);
    chk("chg_change_nodisp", disp(), 0);
    tick;
    for (int i = 0; i < 4; i++) begin
      chk("chg_hold_q", disp(), 3'b100);
      chk("chg_hold_credit", credit, 35);
      tick;
    end
    ack_coin(10);
    chk("chg_disp_d", disp(), 3'b010);
    ack_coin(0);
    chk("chg_done_disp", disp(), 0);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("chg_back_accum", lowCredit, 1);
    for (int i = 1; i <= 7; i++) coin(25, 8'(25 * i), 0);
    coin(10, 185, 0);
    coin(5, 190, 0);
    coin(25, 190, 1);
    coin(10, 200, 0);
    coin(5, 200, 1);
    vendReq = 1;
    tick;
    vendReq = 0;
    chk("max_vend", vend, 1);
    tick;
    chk("max_credit135", credit, 135);
    tick;
    chk("wait_disp_q", disp(), 3'b100);
    dimeDetected = 1;
    vendReq = 1;
    tick;
    dimeDetected = 0;
    vendReq = 0;
    chk("wait_coin_reject", coinReject, 1);
    chk("wait_credit", credit, 135);
    chk("wait_no_low", lowCredit, 0);
    chk("wait_disp_hold", disp(), 3'b100);
    tick;
    reset = 1;
    #1;
    chk("midrst_credit", credit, 0);
    chk("midrst_disp", disp(), 0);
    tick;
    reset = 0;
    tick;
    chk("postrst_disp", disp(), 0);
    quarterDetected = 1;
    dimeDetected = 1;
    tick;
    chk("simul_qd_credit", credit, 25);
    chk("simul_qd_reject", coinReject, 1);
    tick;
    {quarterDetected, dimeDetected} = 2'b00;
    tick;
    nickelDetected = 1;
    dimeDetected = 1;
    tick;
    chk("simul_nd_credit", credit, 30);
    chk("simul_nd_reject", coinReject, 1);
    tick;
    {nickelDetected, dimeDetected} = 2'b00;
    tick;
    coin(25, 55, 0);
    vendReq = 1;
    dimeDetected = 1;
    tick;
    vendReq = 0;
    chk("vc_low", lowCredit, 1);
    chk("vc_novend", vend, 0);
    chk("vc_credit65", credit, 65);
    tick;
    dimeDetected = 0;
    tick;
    vendReq = 1;
    quarterDetected = 1;
    tick;
    vendReq = 0;
    chk("vc_vend", vend, 1);
    chk("vc_credit90", credit, 90);
    chk("vc_noreject", coinReject, 0);
    tick;
    quarterDetected = 0;
    chk("vc_credit25", credit, 25);
    tick;
    chk("vc_disp_q", disp(), 3'b100);
    ack_coin(0);
    chk("vc_done", disp(), 0);
    coin(25, 25, 0);
    coin(10, 35, 0);
    coin(5, 40, 0);
    cancelReq = 1;
    vendReq = 1;
    tick;
    cancelReq = 0;
    vendReq = 0;
    chk("cancel_novend", vend, 0);
`ifdef COIN_CANCEL_EN
    chk("cancel_no_low", lowCredit, 0);
    tick;
    chk("cancel_disp_q", disp(), 3'b100);
    ack_coin(15);
    chk("cancel_disp_d", disp(), 3'b010);
    ack_coin(5);
    chk("cancel_disp_n", disp(), 3'b001);
    ack_coin(0);
    chk("cancel_done", disp(), 0);
`else
    chk("cancel_ignored_low", lowCredit, 1);
    tick;
    tick;
    chk("cancel_ignored_disp", disp(), 0);
    chk("cancel_ignored_credit", credit, 40);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
